io_irq_timer: RTL and testbench



---
 rtl/io_irq_timer_pkg.sv | 34 +++
 rtl/io_timer16.sv | 56 +++++
 rtl/io_irq_timer.sv | 139 +++++++++++++
 tb/tb_io_irq_timer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_irq_timer_pkg.sv
// Shared definitions for the j1 IO-bus timer / interrupt block.
// Holds the register offsets within the 16-word IO window, the CTRL bit
// positions, and where each interrupt source lands in PENDING/MASK/int_rqst.
package io_irq_timer_pkg;

  // Register offsets (io_addr[3:0])
  localparam logic [3:0] OFS_T0_RELOAD = 4'h0;
  localparam logic [3:0] OFS_T0_COUNT  = 4'h1;
  localparam logic [3:0] OFS_T0_CTRL   = 4'h2;
  localparam logic [3:0] OFS_T1_RELOAD = 4'h4;
  localparam logic [3:0] OFS_T1_COUNT  = 4'h5;
  localparam logic [3:0] OFS_T1_CTRL   = 4'h6;
  localparam logic [3:0] OFS_PENDING   = 4'h8;
  localparam logic [3:0] OFS_MASK      = 4'h9;
  localparam logic [3:0] OFS_SET       = 4'hA;
  localparam logic [3:0] OFS_SRC       = 4'hB;

  // CTRL register layout
  localparam int CTRL_EN      = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_W       = 2;

  // Interrupt bit assignment; bit 7 is the highest priority at the core
  localparam int IRQ_T0      = 7;
  localparam int IRQ_T1      = 6;
  localparam int IRQ_EXT_LSB = 0;
  localparam int EXT_W       = 6;

  // CTRL is narrower than the bus; upper bits always read as zero
  function automatic logic [15:0] ctrl_word(input logic [CTRL_W-1:0] c);
    return {{(16-CTRL_W){1'b0}}, c};
  endfunction

endpackage

// File: rtl/io_timer16.sv
// One 16-bit down-count timer with reload and one-shot support.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   tick            shared prescaler tick (one cycle wide)
//   wdata           IO write data
//   reload_wr       write strobe for RELOAD
//   count_wr        write strobe for COUNT
//   ctrl_wr         write strobe for CTRL (EN, ONESHOT)
//   reload, count   current register values for readback
//   ctrl            current CTRL bits for readback
//   expire          one-cycle pulse when the count expires on a tick
module io_timer16
  import io_irq_timer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic [15:0]       wdata,
  input  logic              reload_wr,
  input  logic              count_wr,
  input  logic              ctrl_wr,
  output logic [15:0]       reload,
  output logic [15:0]       count,
  output logic [CTRL_W-1:0] ctrl,
  output logic              expire
);

  // A software write to COUNT in a tick cycle takes precedence, so it also
  // suppresses the expiry that the old zero count would have produced.
  assign expire = tick && ctrl[CTRL_EN] && !count_wr && (count == 16'h0000);

  // Expiry reloads from the RELOAD value held before any same-cycle write.
  // A CTRL write overrides the one-shot auto-disable.
  always_ff @(posedge clk) begin
    if (reset) begin
      reload <= 16'h0000;
      count  <= 16'h0000;
      ctrl   <= '0;
    end else begin
      if (reload_wr) begin
        reload <= wdata;
      end
      if (count_wr) begin
        count <= wdata;
      end else if (tick && ctrl[CTRL_EN]) begin
        count <= (count == 16'h0000) ? reload : count - 16'd1;
      end
      if (ctrl_wr) begin
        ctrl <= wdata[CTRL_W-1:0];
      end else if (expire && ctrl[CTRL_ONESHOT]) begin
        ctrl[CTRL_EN] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/io_irq_timer.sv
// IO-bus responder for the j1 core: two 16-bit timers sharing a prescaler
// plus an 8-source interrupt pending/mask unit.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   io_rd        one-cycle read strobe
//   io_wr        one-cycle write strobe (wins if it coincides with io_rd)
//   io_addr      IO address; block selected when io_addr[15:4] == BASE[15:4]
//   io_wdata     write data
//   io_rdata     registered read data, held until the next selected read
//   ext_irq      external event lines, synchronous to clk
//   int_rqst     registered PENDING & MASK
module io_irq_timer
  import io_irq_timer_pkg::*;
#(
  parameter logic [15:0] BASE     = 16'h0040,
  parameter int          PRESC_W  = 8,
  parameter int          EXT_EDGE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_rd,
  input  logic             io_wr,
  input  logic [15:0]      io_addr,
  input  logic [15:0]      io_wdata,
  output logic [15:0]      io_rdata,
  input  logic [EXT_W-1:0] ext_irq,
  output logic [7:0]       int_rqst
);

  localparam logic [PRESC_W-1:0] PRESC_ONE = 1;

  logic               sel;
  logic               wr_en;
  logic               rd_en;
  logic [3:0]         ofs;
  logic [PRESC_W-1:0] presc;
  logic               tick;
  logic [EXT_W-1:0]   ext_prev;
  logic [EXT_W-1:0]   ext_hit;
  logic [7:0]         pending;
  logic [7:0]         mask;
  logic [7:0]         set_bits;
  logic [7:0]         clr_bits;
  logic [15:0]        rdata_next;
  logic [15:0]        t0_reload, t0_count, t1_reload, t1_count;
  logic [CTRL_W-1:0]  t0_ctrl, t1_ctrl;
  logic               t0_expire, t1_expire;

  assign sel   = (io_addr[15:4] == BASE[15:4]);
  assign ofs   = io_addr[3:0];
  assign wr_en = io_wr && sel;
  assign rd_en = io_rd && sel && !io_wr;
  assign tick  = &presc;

  // Edge mode keeps one cycle of history so a held-high line latches once.
  assign ext_hit = (EXT_EDGE != 0) ? (ext_irq & ~ext_prev) : ext_irq;

  io_timer16 u_timer0 (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .wdata     (io_wdata),
    .reload_wr (wr_en && (ofs == OFS_T0_RELOAD)),
    .count_wr  (wr_en && (ofs == OFS_T0_COUNT)),
    .ctrl_wr   (wr_en && (ofs == OFS_T0_CTRL)),
    .reload    (t0_reload),
    .count     (t0_count),
    .ctrl      (t0_ctrl),
    .expire    (t0_expire)
  );

  io_timer16 u_timer1 (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .wdata     (io_wdata),
    .reload_wr (wr_en && (ofs == OFS_T1_RELOAD)),
    .count_wr  (wr_en && (ofs == OFS_T1_COUNT)),
    .ctrl_wr   (wr_en && (ofs == OFS_T1_CTRL)),
    .reload    (t1_reload),
    .count     (t1_count),
    .ctrl      (t1_ctrl),
    .expire    (t1_expire)
  );

  // Collect all set and clear requests for PENDING in this cycle
  always_comb begin
    set_bits = 8'h00;
    set_bits[IRQ_T0] = t0_expire;
    set_bits[IRQ_T1] = t1_expire;
    set_bits[IRQ_EXT_LSB +: EXT_W] = ext_hit;
    if (wr_en && (ofs == OFS_SET)) begin
      set_bits = set_bits | io_wdata[7:0];
    end
    clr_bits = (wr_en && (ofs == OFS_PENDING)) ? io_wdata[7:0] : 8'h00;
  end

  // Read multiplexer; unmapped offsets and write-only SET read as zero
  always_comb begin
    rdata_next = 16'h0000;
    case (ofs)
      OFS_T0_RELOAD: rdata_next = t0_reload;
      OFS_T0_COUNT:  rdata_next = t0_count;
      OFS_T0_CTRL:   rdata_next = ctrl_word(t0_ctrl);
      OFS_T1_RELOAD: rdata_next = t1_reload;
      OFS_T1_COUNT:  rdata_next = t1_count;
      OFS_T1_CTRL:   rdata_next = ctrl_word(t1_ctrl);
      OFS_PENDING:   rdata_next = {8'h00, pending};
      OFS_MASK:      rdata_next = {8'h00, mask};
      OFS_SRC:       rdata_next = {{(16-EXT_W){1'b0}}, ext_irq};
      default:       rdata_next = 16'h0000;
    endcase
  end

  // Set requests are applied after clears so a colliding set keeps the bit.
  // int_rqst samples the registers as they stood, giving one cycle of lag.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc    <= '0;
      ext_prev <= '0;
      pending  <= 8'h00;
      mask     <= 8'h00;
      int_rqst <= 8'h00;
      io_rdata <= 16'h0000;
    end else begin
      presc    <= presc + PRESC_ONE;
      ext_prev <= ext_irq;
      pending  <= (pending & ~clr_bits) | set_bits;
      int_rqst <= pending & mask;
      if (wr_en && (ofs == OFS_MASK)) begin
        mask <= io_wdata[7:0];
      end
      if (rd_en) begin
        io_rdata <= rdata_next;
      end
    end
  end

endmodule

// File: tb/tb_io_irq_timer.sv
// Self-checking bench for io_irq_timer (PRESC_W=2, so one tick every 4 clocks).
// A cycle-level behavioural model of the register map is compared against
// io_rdata and int_rqst every cycle; directed literal checks pin the model.
// A second instance in level mode shares the bus to cover EXT_EDGE=0.
module tb_io_irq_timer;

  localparam int PW     = 2;
  localparam int PERIOD = 1 << PW;
  localparam logic [15:0] BASE = 16'h0040;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        io_rd = 1'b0;
  logic        io_wr = 1'b0;
  logic [15:0] io_addr = 16'h0000;
  logic [15:0] io_wdata = 16'h0000;
  logic [5:0]  ext_irq = 6'h00;
  logic [15:0] io_rdata, lvl_rdata;
  logic [7:0]  int_rqst, lvl_rqst;

  int checks = 0;
  int errors = 0;
  int tb_cyc = 0;

  always #5 clk = ~clk;

  io_irq_timer #(.BASE(BASE), .PRESC_W(PW), .EXT_EDGE(1)) dut (
    .clk(clk), .reset(reset), .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .ext_irq(ext_irq), .int_rqst(int_rqst)
  );

  io_irq_timer #(.BASE(BASE), .PRESC_W(PW), .EXT_EDGE(0)) dut_lvl (
    .clk(clk), .reset(reset), .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr),
    .io_wdata(io_wdata), .io_rdata(lvl_rdata), .ext_irq(ext_irq), .int_rqst(lvl_rqst)
  );

  // ---------------- behavioural model ----------------
  logic [15:0] m_reload [2];
  logic [15:0] m_count  [2];
  logic        m_en     [2];
  logic        m_os     [2];
  logic [7:0]  m_pend, m_mask, m_int;
  logic [15:0] m_rdata;
  logic [5:0]  m_prev;
  int          m_cyc;
  bit          model_valid = 1'b0;

  function automatic logic [15:0] model_read(input logic [3:0] o);
    case (o)
      4'h0: return m_reload[0];
      4'h1: return m_count[0];
      4'h2: return {14'b0, m_os[0], m_en[0]};
      4'h4: return m_reload[1];
      4'h5: return m_count[1];
      4'h6: return {14'b0, m_os[1], m_en[1]};
      4'h8: return {8'h00, m_pend};
      4'h9: return {8'h00, m_mask};
      4'hB: return {10'b0, ext_irq};
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin : model_blk
    logic       sel, wr, rd, tk, cwr;
    logic [3:0] o;
    logic       ev [2];
    logic [7:0] set, clr;
    tb_cyc <= tb_cyc + 1;
    if (reset) begin
      for (int t = 0; t < 2; t++) begin
        m_reload[t] = 16'h0; m_count[t] = 16'h0; m_en[t] = 1'b0; m_os[t] = 1'b0;
      end
      m_pend = 8'h0; m_mask = 8'h0; m_int = 8'h0; m_rdata = 16'h0; m_prev = 6'h0;
      m_cyc = 0;
      model_valid = 1'b1;
    end else begin
      sel = (io_addr[15:4] == BASE[15:4]);
      o   = io_addr[3:0];
      wr  = io_wr && sel;
      rd  = io_rd && sel && !io_wr;
      tk  = ((m_cyc % PERIOD) == PERIOD - 1);
      if (rd) m_rdata = model_read(o);
      m_int = m_pend & m_mask;
      for (int t = 0; t < 2; t++) begin
        cwr   = wr && (o == 4'(4*t + 1));
        ev[t] = 1'b0;
        if (tk && m_en[t] && !cwr) begin
          if (m_count[t] == 16'h0) begin
            ev[t] = 1'b1;
            m_count[t] = m_reload[t];
            if (m_os[t]) m_en[t] = 1'b0;
          end else begin
            m_count[t] = m_count[t] - 16'd1;
          end
        end
        if (wr && (o == 4'(4*t))) m_reload[t] = io_wdata;
        if (cwr) m_count[t] = io_wdata;
        if (wr && (o == 4'(4*t + 2))) begin
          m_en[t] = io_wdata[0];
          m_os[t] = io_wdata[1];
        end
      end
      set = {ev[0], ev[1], ext_irq & ~m_prev};
      if (wr && o == 4'hA) set = set | io_wdata[7:0];
      clr = (wr && o == 4'h8) ? io_wdata[7:0] : 8'h00;
      m_pend = (m_pend & ~clr) | set;
      if (wr && o == 4'h9) m_mask = io_wdata[7:0];
      m_prev = ext_irq;
      m_cyc++;
    end
  end

  // ---------------- checking ----------------
  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("model_rdata", io_rdata, m_rdata);
      checkOutput("model_irq", {8'h00, int_rqst}, {8'h00, m_int});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] addr,
                               input logic [15:0] data);
    io_rd = rd; io_wr = wr; io_addr = addr; io_wdata = data;
    @(posedge clk); #1;
    io_rd = 1'b0; io_wr = 1'b0;
  endtask

  task automatic busWrite(input logic [3:0] o, input logic [15:0] data);
    applyStimulus(1'b0, 1'b1, BASE | {12'h000, o}, data);
  endtask

  task automatic busRead(input logic [3:0] o);
    applyStimulus(1'b1, 1'b0, BASE | {12'h000, o}, 16'h0000);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic waitPhase(input int p);
    int n = 0;
    while ((m_cyc % PERIOD) != p && n < 16) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic waitIrq(input int b, input logic v, output int at);
    int n = 0;
    while (int_rqst[b] !== v && n < 64) begin
      @(posedge clk); #1; n++;
    end
    at = tb_cyc;
    checkOutput($sformatf("wait_irq%0d_is_%0d", b, v), {15'h0, int_rqst[b]}, {15'h0, v});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int c1, c2, cx;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("reset_irq", {8'h00, int_rqst}, 16'h0000);
    checkOutput("reset_rdata", io_rdata, 16'h0000);

    // 1: every offset reads zero after reset
    for (int i = 0; i < 16; i++) begin
      busRead(4'(i));
      checkOutput($sformatf("reset_rd_%0d", i), io_rdata, 16'h0000);
    end

    // 2: periodic timer 0, reload 3 -> expiry every 16 clocks
    busWrite(4'h0, 16'd3);
    busWrite(4'h1, 16'd3);
    busWrite(4'h9, 16'h0080);
    busWrite(4'h2, 16'h0001);
    waitIrq(7, 1'b1, c1);
    busWrite(4'h8, 16'h0080);
    waitIrq(7, 1'b0, cx);
    waitIrq(7, 1'b1, c2);
    checkOutput("t0_period", 16'(c2 - c1), 16'd16);
    busWrite(4'h2, 16'h0000);
    busWrite(4'h8, 16'h00FF);
    busRead(4'h0);
    checkOutput("t0_reload_rd", io_rdata, 16'h0003);
    applyStimulus(1'b1, 1'b0, 16'h0123, 16'h0000);
    checkOutput("unsel_read_hold", io_rdata, 16'h0003);

    // 3: one-shot timer 1 expires once and clears EN
    busWrite(4'h4, 16'h0000);
    busWrite(4'h5, 16'h0000);
    busWrite(4'h6, 16'h0003);
    idle(8);
    busRead(4'h6);
    checkOutput("t1_oneshot_ctrl", io_rdata, 16'h0002);
    busRead(4'h8);
    checkOutput("t1_oneshot_pend", io_rdata, 16'h0040);
    busWrite(4'h8, 16'h0040);
    idle(12);
    busRead(4'h8);
    checkOutput("t1_oneshot_once", io_rdata, 16'h0000);

    // 4: external line held high; edge vs level latching
    busWrite(4'h9, 16'h0004);
    ext_irq = 6'b000100;
    idle(2);
    checkOutput("ext_irq_out", {8'h00, int_rqst}, 16'h0004);
    busRead(4'h8);
    checkOutput("ext_pend", io_rdata, 16'h0004);
    busRead(4'hB);
    checkOutput("ext_src", io_rdata, 16'h0004);
    busWrite(4'h8, 16'h0004);
    busRead(4'h8);
    checkOutput("ext_edge_w1c", io_rdata, 16'h0000);
    checkOutput("ext_level_reset", lvl_rdata, 16'h0004);
    idle(4);
    ext_irq = 6'b000000;
    idle(1);
    busRead(4'h8);
    checkOutput("ext_edge_stays", io_rdata, 16'h0000);
    busWrite(4'h8, 16'h0004);
    busRead(4'h8);
    checkOutput("ext_level_clear", lvl_rdata, 16'h0000);

    // 5: SET / W1C back to back, W1C of b6 colliding with timer 1 expiry
    busWrite(4'h4, 16'h0000);
    busWrite(4'h6, 16'h0001);
    busWrite(4'h9, 16'h0041);
    waitPhase(1);
    busWrite(4'hA, 16'h0041);
    busWrite(4'h8, 16'h0001);
    busWrite(4'h8, 16'h0040);
    busRead(4'h8);
    checkOutput("set_wins_pend", io_rdata, 16'h0040);
    checkOutput("set_wins_irq", {8'h00, int_rqst}, 16'h0040);
    busWrite(4'h6, 16'h0000);
    busWrite(4'h8, 16'h00FF);

    // 6: COUNT write in a tick cycle beats expiry; then reset mid-count
    busWrite(4'h0, 16'd7);
    busWrite(4'h1, 16'd0);
    waitPhase(PERIOD - 1);
    busWrite(4'h2, 16'h0001);
    waitPhase(PERIOD - 1);
    busWrite(4'h1, 16'd5);
    busRead(4'h1);
    checkOutput("count_write_wins", io_rdata, 16'h0005);
    busRead(4'h8);
    checkOutput("count_write_no_exp", io_rdata, 16'h0000);
    busWrite(4'h9, 16'h00FF);
    busWrite(4'hA, 16'h0001);
    idle(1);
    checkOutput("set_irq", {8'h00, int_rqst}, 16'h0001);
    busRead(4'h9);
    checkOutput("mask_rd", io_rdata, 16'h00FF);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("midreset_irq", {8'h00, int_rqst}, 16'h0000);
    checkOutput("midreset_rdata", io_rdata, 16'h0000);
    busRead(4'h9);
    checkOutput("midreset_mask", io_rdata, 16'h0000);
    busRead(4'h1);
    checkOutput("midreset_count", io_rdata, 16'h0000);
    busRead(4'h2);
    checkOutput("midreset_ctrl", io_rdata, 16'h0000);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
